fifo_ctrl: RTL and testbench

//  Control unit for the 8-entry FIFO storage RAM (memoria). Turns push/pop requests into

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_ptr.sv | 27 ++
 rtl/fifo_ctrl.sv | 115 +++++++++++
 tb/tb_fifo_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO control slice: pointer/count widths, depth and
// default occupancy thresholds used by fifo_ctrl and its pointer counters.
package fifo_pkg;

  localparam int FIFO_PTR_W     = 3;
  localparam int FIFO_DEPTH     = 1 << FIFO_PTR_W;
  localparam int FIFO_CNT_W     = FIFO_PTR_W + 1;
  localparam int FIFO_AF_THRESH = 6;
  localparam int FIFO_AE_THRESH = 2;

  // Transaction classification used when deciding whether a request is legal.
  typedef enum logic [1:0] {
    REQ_NONE  = 2'b00,
    REQ_OK    = 2'b01,
    REQ_OVER  = 2'b10,
    REQ_UNDER = 2'b11
  } fifo_req_e;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around address counter for the FIFO storage RAM. Advances by one on each
// cycle with inc high; natural binary overflow gives the 2**W-1 -> 0 wrap.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int W = FIFO_PTR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_reg;

  // Pointer register: cleared asynchronously, steps on accepted operations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (inc) begin
      ptr_reg <= ptr_reg + 1'b1;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_ctrl.sv
// Control unit for one FIFO in front of its storage RAM: accepts push/pop
// requests, drives the RAM strobes and addresses, tracks occupancy and flags.
// Build option FIFO_ERR_STICKY_EN: when defined, error latches until reset;
// otherwise error is a one-cycle registered pulse after each illegal request.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH = FIFO_PTR_W,
  parameter int AF_THRESH = FIFO_AF_THRESH,
  parameter int AE_THRESH = FIFO_AE_THRESH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  output logic [PTR_WIDTH-1:0] wr_ptr,
  output logic [PTR_WIDTH-1:0] rd_ptr,
  output logic                 write_enable,
  output logic                 read_enable,
  output logic                 data_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   count,
  output logic                 error
);

  localparam int CNT_W = PTR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(1 << PTR_WIDTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  logic [CNT_W-1:0]     count_reg;
  logic                 data_valid_reg;
  logic                 error_reg;
  logic                 acc_wr;
  logic                 acc_rd;
  fifo_req_e            wr_req;
  fifo_req_e            rd_req;
  logic                 illegal;
  logic [1:0]           inc_vec;
  logic [PTR_WIDTH-1:0] ptr_vec [2];

  // Flags come straight from the registered count, no extra latency.
  always_comb begin
    full         = (count_reg == DEPTH_C);
    empty        = (count_reg == '0);
    almost_full  = (count_reg >= AF_C);
    almost_empty = (count_reg <= AE_C);
  end

  // Request classification: a push into a full FIFO is still fine when a pop
  // frees the slot in the same cycle (RAM reads the old word first); a pop
  // from an empty FIFO is always rejected since there is no write bypass.
  always_comb begin
    wr_req = REQ_NONE;
    rd_req = REQ_NONE;
    if (push) begin
      wr_req = (!full || pop) ? REQ_OK : REQ_OVER;
    end
    if (pop) begin
      rd_req = (!empty) ? REQ_OK : REQ_UNDER;
    end
    acc_wr  = (wr_req == REQ_OK) && !reset;
    acc_rd  = (rd_req == REQ_OK) && !reset;
    illegal = (wr_req == REQ_OVER) || (rd_req == REQ_UNDER);
  end

  assign write_enable = acc_wr;
  assign read_enable  = acc_rd;

  // Occupancy, read-data-valid tracking and error reporting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg      <= '0;
      data_valid_reg <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      case ({acc_wr, acc_rd})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // The RAM registers its read, so the word is on its output one cycle later.
      data_valid_reg <= acc_rd;
`ifdef FIFO_ERR_STICKY_EN
      error_reg <= error_reg | illegal;
`else
      error_reg <= illegal;
`endif
    end
  end

  assign inc_vec = {acc_rd, acc_wr};

  // Index 0 is the write pointer, index 1 the read pointer.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
      fifo_ptr #(.W(PTR_WIDTH)) u_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_vec[gi]),
        .ptr   (ptr_vec[gi])
      );
    end
  endgenerate

  assign wr_ptr     = ptr_vec[0];
  assign rd_ptr     = ptr_vec[1];
  assign count      = count_reg;
  assign data_valid = data_valid_reg;
  assign error      = error_reg;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a 12-bit, 8-entry registered-read RAM
// beside it. A queue-based reference model predicts occupancy, pointers,
// strobes, popped data and the error flag (pulse or sticky per FIFO_ERR_STICKY_EN).
module tb_fifo_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [2:0]  wr_ptr, rd_ptr;
  logic        write_enable, read_enable, data_valid;
  logic        full, empty, almost_full, almost_empty, error;
  logic [3:0]  count;

  logic [11:0] wdata = '0;
  logic [11:0] rdata;
  logic [11:0] mem [0:7];

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [11:0] mq [$];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic        exp_we, exp_re, exp_dv, exp_err;
  logic        obs_we, obs_re;
  logic [11:0] exp_word;

  always #5 clk = ~clk;

  fifo_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .error        (error)
  );

  // storage RAM: synchronous write, registered read
  always @(posedge clk) begin
    if (write_enable) mem[wr_ptr] <= wdata;
    if (read_enable)  rdata <= mem[rd_ptr];
  end

  task automatic model_reset();
    mq.delete();
    wr_cnt  = 0;
    rd_cnt  = 0;
    exp_dv  = 1'b0;
    exp_err = 1'b0;
    exp_we  = 1'b0;
    exp_re  = 1'b0;
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic drive_cycle(input logic p, input logic q, input logic [11:0] d);
    logic bad;
    push = p; pop = q; wdata = d;
    #1;
    obs_we = write_enable;
    obs_re = read_enable;
    exp_re = q && (mq.size() > 0);
    exp_we = p && ((mq.size() < 8) || q);
    bad    = (p && mq.size() == 8 && !q) || (q && mq.size() == 0);
    if (exp_re) exp_word = mq.pop_front();
    if (exp_we) mq.push_back(d);
    wr_cnt += int'(exp_we);
    rd_cnt += int'(exp_re);
    exp_dv = exp_re;
`ifdef FIFO_ERR_STICKY_EN
    exp_err = exp_err | bad;
`else
    exp_err = bad;
`endif
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++; if (count !== 4'd0)   begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin errors++; $display("FAIL reset_flags got %b exp 1100", {empty, almost_empty, full, almost_full}); end
    checks++; if ({wr_ptr, rd_ptr} !== 6'd0) begin errors++; $display("FAIL reset_ptrs got %0d/%0d exp 0/0", wr_ptr, rd_ptr); end
    checks++; if ({data_valid, error} !== 2'b00) begin errors++; $display("FAIL reset_dv_err got %b exp 00", {data_valid, error}); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    $display("reset: count=%0d empty=%b", count, empty);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      drive_cycle(1'b1, 1'b0, 12'(i));
      checks++; if (count !== 4'(i)) begin errors++; $display("FAIL fill_count got %0d exp %0d", count, i); end
      checks++; if (almost_full !== (i >= 6)) begin errors++; $display("FAIL fill_af got %b at count %0d", almost_full, i); end
      checks++; if (full !== (i == 8)) begin errors++; $display("FAIL fill_full got %b at count %0d", full, i); end
      checks++; if (wr_ptr !== 3'(i % 8)) begin errors++; $display("FAIL fill_wrptr got %0d exp %0d", wr_ptr, i % 8); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL fill_err got %b exp 0", error); end
      $display("push 0x%03h: count=%0d af=%b full=%b wr_ptr=%0d", i, count, almost_full, full, wr_ptr);
    end
  endtask

  task automatic test_overflow();
    drive_cycle(1'b1, 1'b0, 12'h123);
    checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL ovf_we got %b exp 0", obs_we); end
    checks++; if (wr_ptr !== 3'd0 || count !== 4'd8) begin errors++; $display("FAIL ovf_state got wr_ptr=%0d count=%0d exp 0/8", wr_ptr, count); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_err got %b exp 1", error); end
    $display("overflow: we=%b count=%0d error=%b", obs_we, count, error);
    drive_cycle(1'b0, 1'b0, 12'h000);
    checks++; if (error !== exp_err) begin errors++; $display("FAIL ovf_err_after got %b exp %b", error, exp_err); end
    $display("idle after overflow: error=%b", error);
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      drive_cycle(1'b0, 1'b1, 12'h000);
      checks++; if (data_valid !== 1'b1 || rdata !== 12'(i)) begin errors++; $display("FAIL drain_data got dv=%b 0x%03h exp 1 0x%03h", data_valid, rdata, i); end
      checks++; if (almost_empty !== ((8 - i) <= 2)) begin errors++; $display("FAIL drain_ae got %b at count %0d", almost_empty, 8 - i); end
      checks++; if (count !== 4'(8 - i)) begin errors++; $display("FAIL drain_count got %0d exp %0d", count, 8 - i); end
      $display("pop: data=0x%03h dv=%b count=%0d ae=%b", rdata, data_valid, count, almost_empty);
    end
    checks++; if (empty !== 1'b1 || rd_ptr !== 3'd0) begin errors++; $display("FAIL drain_end got empty=%b rd_ptr=%0d exp 1/0", empty, rd_ptr); end
    drive_cycle(1'b0, 1'b0, 12'h000);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL drain_dv_drop got %b exp 0", data_valid); end
  endtask

  task automatic test_empty_push_pop();
    drive_cycle(1'b1, 1'b1, 12'h0AA);
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL epp_count got %0d exp 1", count); end
    checks++; if (obs_re !== 1'b0 || obs_we !== 1'b1) begin errors++; $display("FAIL epp_strobes got we=%b re=%b exp 1/0", obs_we, obs_re); end
    checks++; if (data_valid !== 1'b0 || error !== 1'b1) begin errors++; $display("FAIL epp_dv_err got dv=%b err=%b exp 0/1", data_valid, error); end
    $display("empty push+pop: count=%0d re=%b dv=%b error=%b", count, obs_re, data_valid, error);
    drive_cycle(1'b0, 1'b1, 12'h000);
    checks++; if (data_valid !== 1'b1 || rdata !== 12'h0AA) begin errors++; $display("FAIL epp_data got dv=%b 0x%03h exp 1 0x0aa", data_valid, rdata); end
    $display("pop: data=0x%03h dv=%b", rdata, data_valid);
  endtask

  task automatic test_full_push_pop();
    logic [2:0] wp0, rp0;
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b0, 12'h0B0 + 12'(i));
    wp0 = wr_ptr; rp0 = rd_ptr;
    drive_cycle(1'b1, 1'b1, 12'h0FF);
    checks++; if (count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL fpp_count got %0d full=%b exp 8/1", count, full); end
    checks++; if (wr_ptr !== wp0 + 3'd1 || rd_ptr !== rp0 + 3'd1) begin errors++; $display("FAIL fpp_ptrs got %0d/%0d exp %0d/%0d", wr_ptr, rd_ptr, wp0 + 3'd1, rp0 + 3'd1); end
    checks++; if (data_valid !== 1'b1 || rdata !== 12'h0B0) begin errors++; $display("FAIL fpp_data got dv=%b 0x%03h exp 1 0x0b0", data_valid, rdata); end
    checks++; if (error !== 1'b0 && exp_err === 1'b0) begin errors++; $display("FAIL fpp_err got %b exp 0", error); end
    $display("full push+pop: count=%0d data=0x%03h", count, rdata);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 1'b1, 12'h000);
      checks++; if (data_valid !== 1'b1 || rdata !== exp_word) begin errors++; $display("FAIL fpp_drain got 0x%03h exp 0x%03h", rdata, exp_word); end
      $display("pop: data=0x%03h", rdata);
    end
    checks++; if (rdata !== 12'h0FF || empty !== 1'b1) begin errors++; $display("FAIL fpp_last got 0x%03h empty=%b exp 0x0ff/1", rdata, empty); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 12'h300 + 12'(i));
    #3;
    reset = 1'b1;
    push  = 1'b1;
    #1;
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL arst_count got %0d empty=%b exp 0/1", count, empty); end
    checks++; if (wr_ptr !== 3'd0 || rd_ptr !== 3'd0) begin errors++; $display("FAIL arst_ptrs got %0d/%0d exp 0/0", wr_ptr, rd_ptr); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL arst_err got %b exp 0", error); end
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL arst_we got %b exp 0", write_enable); end
    $display("async reset: count=%0d wr_ptr=%0d rd_ptr=%0d error=%b", count, wr_ptr, rd_ptr, error);
    @(posedge clk); #1;
    reset = 1'b0;
    push  = 1'b0;
    model_reset();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL arst_hold got %0d exp 0", count); end
  endtask

  task automatic test_random();
    logic p, q;
    int   phase;
    for (int n = 0; n < 400; n++) begin
      phase = (n / 50) % 3;
      p = ($urandom_range(0, 99) < (phase == 0 ? 75 : (phase == 1 ? 25 : 50)));
      q = ($urandom_range(0, 99) < (phase == 0 ? 25 : (phase == 1 ? 75 : 50)));
      drive_cycle(p, q, 12'($urandom));
      checks++;
      if (count !== 4'(mq.size()) || full !== (mq.size() == 8) || empty !== (mq.size() == 0) ||
          almost_full !== (mq.size() >= 6) || almost_empty !== (mq.size() <= 2) ||
          wr_ptr !== 3'(wr_cnt % 8) || rd_ptr !== 3'(rd_cnt % 8) ||
          obs_we !== exp_we || obs_re !== exp_re || data_valid !== exp_dv ||
          error !== exp_err || (exp_dv && rdata !== exp_word)) begin
        errors++;
        $display("FAIL rand_%0d got cnt=%0d wp=%0d rp=%0d we=%b re=%b dv=%b err=%b d=0x%03h exp cnt=%0d wp=%0d rp=%0d we=%b re=%b dv=%b err=%b d=0x%03h",
                 n, count, wr_ptr, rd_ptr, obs_we, obs_re, data_valid, error, rdata,
                 mq.size(), wr_cnt % 8, rd_cnt % 8, exp_we, exp_re, exp_dv, exp_err, exp_word);
      end
      $display("rand %0d: push=%b pop=%b count=%0d error=%b", n, p, q, count, error);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_empty_push_pop();
    test_full_push_pop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
